// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with registered results and valid/ready handshakes.
// Single-cycle ops complete on the accept edge. Variable shifts move one bit
// per cycle. The shift-add multiply is only built when ALU_SEQ_MUL_EN is
// defined; without it, sel 1010 behaves as a reserved op.
//
// state | meaning
// IDLE  | ready for a new op; single-cycle results are registered on accept
// BUSY  | iterating a variable shift or a multiply, one step per cycle
// DONE  | result presented; held stable until the consumer takes it
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic [3:0]       sel_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] f_o,
  output logic             cout_o,
  output logic             zero_o
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic             left_q, left_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_f;
  logic             res_c;
  logic [WIDTH-1:0] shifted;
  logic             shout;

`ifdef ALU_SEQ_MUL_EN
  // Low half starts as the multiplier and drains out as the product fills in.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               mul_q, mul_d;
  logic [WIDTH:0]     mul_sum;
`endif

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      prod_q  <= '0;
      mul_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
`ifdef ALU_SEQ_MUL_EN
      prod_q  <= prod_d;
      mul_q   <= mul_d;
`endif
    end
  end

  // Next-state, single-cycle results and per-cycle iteration steps.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    f_d     = f_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    addend  = '0;
    sum     = '0;
    res_f   = '0;
    res_c   = 1'b0;
    shifted = left_q ? {a_q[WIDTH-2:0], 1'b0} : {1'b0, a_q[WIDTH-1:1]};
    shout   = left_q ? a_q[WIDTH-1] : a_q[0];
`ifdef ALU_SEQ_MUL_EN
    prod_d  = prod_q;
    mul_d   = mul_q;
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = DONE;
          a_d     = a_i;
          left_d  = sel_i[2];
`ifdef ALU_SEQ_MUL_EN
          mul_d   = 1'b0;
`endif
          case (sel_i)
            4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
              case (sel_i[1:0])
                2'b00:   addend = '0;
                2'b01:   addend = b_i;
                2'b10:   addend = ~b_i;
                default: addend = '1;
              endcase
              sum   = {1'b0, a_i} + {1'b0, addend} + {{WIDTH{1'b0}}, cin_i};
              res_f = sum[WIDTH-1:0];
              res_c = sum[WIDTH];
            end
            4'b0100: res_f = a_i & b_i;
            4'b0101: res_f = a_i | b_i;
            4'b0110: res_f = a_i ^ b_i;
            4'b0111: res_f = ~a_i;
            4'b1000: begin
              res_f = {1'b0, a_i[WIDTH-1:1]};
              res_c = a_i[0];
            end
            4'b1100: begin
              res_f = {a_i[WIDTH-2:0], 1'b0};
              res_c = a_i[WIDTH-1];
            end
            4'b1001, 4'b1101: begin
              if (b_i[SHW-1:0] == '0) begin
                res_f = a_i;
              end else begin
                state_d = BUSY;
                cnt_d   = {1'b0, b_i[SHW-1:0]};
              end
            end
`ifdef ALU_SEQ_MUL_EN
            4'b1010: begin
              state_d = BUSY;
              cnt_d   = (SHW+1)'(WIDTH);
              mul_d   = 1'b1;
              prod_d  = {{WIDTH{1'b0}}, b_i};
            end
`endif
            default: ;
          endcase
          if (state_d == DONE) begin
            f_d    = res_f;
            cout_d = res_c;
            zero_d = (res_f == '0);
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_q - 1'b1;
`ifdef ALU_SEQ_MUL_EN
        if (mul_q) begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
          res_f  = prod_d[WIDTH-1:0];
          res_c  = |prod_d[2*WIDTH-1:WIDTH];
        end else begin
          a_d   = shifted;
          res_f = shifted;
          res_c = shout;
        end
`else
        a_d   = shifted;
        res_f = shifted;
        res_c = shout;
`endif
        if (cnt_q == 1) begin
          state_d = DONE;
          f_d     = res_f;
          cout_d  = res_c;
          zero_d  = (res_f == '0);
        end
      end

      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign f_o         = f_q;
  assign cout_o      = cout_q;
  assign zero_o      = zero_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor to the 32-bit combinational ALU.
- Keeps the 4-bit select encoding and the single-cycle operations, generalised to WIDTH bits.
- Adds registered results, a valid/ready handshake on both sides, a zero flag, and multi-cycle ops: variable-distance shifts (1 bit/cycle) and shift-add multiply.
- Sits between an operand issuer and a result consumer in the datapath.

Parameters:
- WIDTH, 32, operand/result width; >=4, power of two.
- SHW, $clog2(WIDTH), shift-amount width (localparam, not overridable).

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  synchronous active-low reset
- in_valid_i  in  1  operands/op valid
- in_ready_o  out  1  block can accept
- a_i  in  WIDTH  operand A
- b_i  in  WIDTH  operand B; low SHW bits = shift distance for variable shifts
- cin_i  in  1  carry-in for arithmetic ops
- sel_i  in  4  operation select
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- f_o  out  WIDTH  result
- cout_o  out  1  carry / shift-out / multiply-overflow
- zero_o  out  1  f_o == 0

Behaviour:
- Reset: the interface is as already decided — one clock; reset is synchronous and active-low (clk_i, rst_ni).
  - rst_ni low at a rising edge forces state IDLE.
  - Reset values: f_o=0, cout_o=0, zero_o=0, out_valid_o=0. in_ready_o=1 from the first edge after release.
  - Reset wins over every other event, including mid-BUSY; a partial result is discarded, never emitted.
- Operation encoding (all modulo 2^WIDTH):
  - 0000: A+cin
  - 0001: A+B+cin
  - 0010: A+~B+cin
  - 0011: A+all-ones+cin
  - 0100: A&B
  - 0101: A|B
  - 0110: A^B
  - 0111: ~A
  - 1000: A>>1 (logical)
  - 1001: A>>B[SHW-1:0] (logical)
  - 1100: A<<1
  - 1101: A<<B[SHW-1:0]
  - 1010: A*B, low WIDTH bits (see macro)
  - 1011, 1110, 1111: reserved -> f=0, cout=0, latency 1
- cout_o:
  - arithmetic: carry out of bit WIDTH-1
  - logic: 0
  - shifts: last bit shifted out; 0 for distance 0
  - multiply: 1 iff the upper WIDTH bits of the full 2*WIDTH product are nonzero
- zero_o = (f_o==0), registered together with f_o.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready_o=1. On in_valid_i&in_ready_o, latch a, b, cin, sel.
    - Single-cycle op, 1000/1100, or variable shift with distance 0: result registered, go to DONE.
    - Variable shift with distance k>0: go to BUSY with counter=k.
    - Multiply: go to BUSY with counter=WIDTH.
  - BUSY: in_ready_o=0. Each cycle: one shift step (shift ops) or one add-shift step (multiply), counter decrements; at counter==1 the final result is registered and the FSM goes to DONE.
  - DONE: out_valid_o=1 and f_o/cout_o/zero_o held stable until out_ready_i=1 at an edge, then go to IDLE.
- Latency, accept edge to out_valid_o high: 1 cycle for single-cycle ops; 1+k for variable shifts; WIDTH+1 for multiply.
- No overlap: at most one op in flight. in_ready_o=0 in BUSY and DONE, and in_valid_i is ignored there; no new accept occurs in the same cycle as a DONE handshake.
- Back-to-back throughput for single-cycle ops: one result every 2 cycles.
- Operand inputs are don't-care except at the accept edge; cin_i is don't-care for non-arithmetic ops.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: sel 1010 performs the iterative multiply described above.
- Undefined: the multiply datapath and its counter use are not synthesised; 1010 behaves as reserved (f=0, cout=0, latency 1).

Test Plan (WIDTH=32):
- Reset then arithmetic: a=A5A5F0F0, b=0F0F5A5A, sel=0001, cin=1 -> one cycle later out_valid=1, f=B4B54B4B, cout=0, zero=0. Repeat with sel=0010, cin=1 -> f=96969696, cout=1.
- Variable shift: a=A5A5F0F0, b=00000004, sel=1101 -> out_valid 5 cycles after accept, f=5A5F0F00, cout=0. Repeat with b=0 -> latency 1, f=A5A5F0F0, cout=0.
- Multiply (macro defined):
  - a=00010003, b=00000005, sel=1010 -> latency 33, f=0005000F, cout=0.
  - a=FFFFFFFF, b=00000002 -> f=FFFFFFFE, cout=1.
  - Macro undefined: the same ops give latency 1, f=0, cout=0.
- Backpressure: sel=0110 with out_ready_i=0 for 5 cycles -> f=AAAAAAAA held stable, out_valid=1, in_ready=0 throughout. Release -> IDLE next cycle. A=B in a later op -> zero=1.
- Reset mid-op: start a multiply, drive rst_ni low on BUSY cycle 10 -> next edge: out_valid=0, f=0, in_ready=1. A new op after reset produces a correct result with no stale data.
- Reserved/ignore: sel=1111 -> latency 1, f=0, cout=0. in_valid_i pulsed during BUSY -> no second result produced.
